barrel_seq: RTL

- Command sequencer that sits directly upstream of the registered 8-bit barrel rotator stage and drives its load/select/data inputs.
- Accepts rotate commands (byte, amount, direction) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the rotator, waits its fixed latency, captures the rotated byte and returns it over a second valid/ready handshake.
- Lets the rotator be driven by a stream producer instead of raw per-cycle stimulus.

---
 rtl/barrel_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/barrel_seq.sv
// Command sequencer feeding a registered barrel rotator: buffers rotate commands in a FIFO,
// issues them one at a time, waits the rotator latency and hands each result downstream.
module barrel_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = 3,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [SELW-1:0]  cmd_amt,
  input  logic             cmd_dir,
  output logic             bar_load,
  output logic [SELW-1:0]  bar_sel,
  output logic [WIDTH-1:0] bar_data,
  input  logic [WIDTH-1:0] bar_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_wait_cnt;
  logic             r_bar_load;
  logic [SELW-1:0]  r_bar_sel;
  logic [WIDTH-1:0] r_bar_data;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [7:0]       r_done_cnt;

  logic [WIDTH-1:0] r_fifo_data [DEPTH];
  logic [SELW-1:0]  r_fifo_sel  [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [SELW-1:0]  w_push_sel;
  logic [WIDTH-1:0] w_head_data;
  logic [SELW-1:0]  w_head_sel;

  assign w_full      = (r_count == (PtrW + 1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = cmd_valid & ~w_full;
  // The only two places a command leaves the FIFO: idle pickup and the result handoff edge.
  assign w_pop       = ~w_empty & ((r_state == StIdle) | ((r_state == StHold) & res_ready));
  // A left rotate by n equals a right rotate by (2**SELW - n) mod 2**SELW.
  assign w_push_sel  = cmd_dir ? ({SELW{1'b0}} - cmd_amt) : cmd_amt;
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_sel  = r_fifo_sel[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_sel[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= cmd_data;
        r_fifo_sel[r_wr_ptr]  <= w_push_sel;
        r_wr_ptr              <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= '0;
      r_bar_load  <= 1'b0;
      r_bar_sel   <= '0;
      r_bar_data  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_done_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_bar_sel  <= w_head_sel;
        r_bar_data <= w_head_data;
      end
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_bar_load <= 1'b1;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_bar_load <= 1'b0;
          r_wait_cnt <= CntW'(LAT - 1);
          r_state    <= StWait;
        end
        StWait: begin
          if (r_wait_cnt == '0) begin
            r_res_data  <= bar_dout;
            r_res_valid <= 1'b1;
            r_state     <= StHold;
          end else begin
            r_wait_cnt <= r_wait_cnt - CntW'(1);
          end
        end
        StHold: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 8'd1;
            if (w_pop) begin
              r_bar_load <= 1'b1;
              r_state    <= StIssue;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready = ~w_full;
  assign bar_load  = r_bar_load;
  assign bar_sel   = r_bar_sel;
  assign bar_data  = r_bar_data;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign done_cnt  = r_done_cnt;
  assign busy      = (r_state != StIdle) | ~w_empty;

endmodule
